// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mul_sequencer
// Description : Iterative shift-add multiplier controller for the EX stage.
//               Executes mul / mulh / mulhu in a fixed WIDTH+2 cycle
//               sequence, stalling the pipeline until the result is ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall_EX,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [3:0] C_OP_MUL   = 4'b0101;
  localparam logic [3:0] C_OP_MULH  = 4'b0110;
  localparam logic [3:0] C_OP_MULHU = 4'b0111;
  localparam int         CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   result_q;
  logic               neg_q;
  logic               hi_q;
  logic               done_q;

  logic               op_valid_d;
  logic               is_mulh_d;
  logic [WIDTH-1:0]   abs_a_d;
  logic [WIDTH-1:0]   abs_b_d;
  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] acc_step_d;
  logic [2*WIDTH-1:0] acc_fix_d;

  // Operand decode, magnitude conversion and one shift-add iteration.
  // The most negative value maps onto itself, which is exactly its unsigned
  // magnitude, so no extra bit is needed for the operands.
  always_comb begin
    op_valid_d = (op == C_OP_MUL) || (op == C_OP_MULH) || (op == C_OP_MULHU);
    is_mulh_d  = (op == C_OP_MULH);
    abs_a_d    = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    abs_b_d    = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    sum_d      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    acc_step_d = {sum_d, acc_q[WIDTH-1:1]};
    acc_fix_d  = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
  end

  // Stall is combinational so the pipeline freezes in the very cycle the
  // multiply is accepted; reset and flush always release it.
  assign stall_EX = !rst && !flush &&
                    (((state_q == S_IDLE) && start && op_valid_d) ||
                     (state_q == S_BUSY) || (state_q == S_FIX));
  assign done     = done_q;
  assign result   = result_q;

  // Sequencer: latch operands, iterate WIDTH times, sign-fix, then present.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      done_q   <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start && op_valid_d) begin
            mcand_q  <= is_mulh_d ? abs_a_d : a;
            mplier_q <= is_mulh_d ? abs_b_d : b;
            neg_q    <= is_mulh_d && (a[WIDTH-1] ^ b[WIDTH-1]);
            hi_q     <= (op != C_OP_MUL);
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc_q    <= acc_step_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST_CNT) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          acc_q    <= acc_fix_d;
          result_q <= hi_q ? acc_fix_d[2*WIDTH-1:WIDTH] : acc_fix_d[WIDTH-1:0];
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          // The instruction that issued this multiply is still in EX, so
          // start is deliberately ignored here.
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_sequencer
// Description : Self-checking bench for mul_sequencer. A driver issues
//               directed and random multiplies and queues reference results;
//               a monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall_EX;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  mul_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .stall_EX (stall_EX),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference product from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_mul(input logic [3:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    longint unsigned up;
    longint          sp;
    logic [63:0]     r;
    up = {32'b0, x} * {32'b0, y};
    sp = longint'($signed(x)) * longint'($signed(y));
    if (o == 4'b0101)      r = up;
    else if (o == 4'b0111) r = {up[63:32], 32'b0};
    else                   r = {sp[63:32], 32'b0};
    return (o == 4'b0101) ? r[31:0] : r[63:32];
  endfunction

  function automatic bit is_valid(input logic [3:0] o);
    return (o == 4'b0101) || (o == 4'b0110) || (o == 4'b0111);
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done result=%h at %0t",
                 result, $time);
      end else begin
        chk("result", result, exp_q.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    bit v;
    int n;
    v = is_valid(o);
    n = v ? 35 : 4;
    start = 1'b1; op = o; a = x; b = y;
    if (v) exp_q.push_back(ref_mul(o, x, y));
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("stall", {31'b0, stall_EX}, {31'b0, (v && c <= 33)});
      chk("done", {31'b0, done}, {31'b0, (v && c == 34)});
      @(posedge clk); #1;
      if (v && c == 0) begin
        a  = $urandom;
        b  = $urandom;
        op = 4'($urandom_range(0, 15));
      end
    end
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_stall", {31'b0, stall_EX}, 32'd0);
      chk("idle_done", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // Flush asserted during cycle fc of an operation; no result is expected.
  task automatic run_flush(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                           input int fc);
    start = 1'b1; op = o; a = x; b = y;
    for (int c = 0; c <= fc; c++) begin
      @(negedge clk);
      chk("flush_stall", {31'b0, stall_EX}, {31'b0, (c < fc)});
      chk("flush_done", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
      if (c == fc - 1) flush = 1'b1;
      if (c == fc) flush = 1'b0;
    end
  endtask

  // Reset asserted for two cycles starting at cycle rc of an operation.
  task automatic run_reset(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                           input int rc);
    start = 1'b1; op = o; a = x; b = y;
    for (int c = 0; c <= rc + 2; c++) begin
      @(negedge clk);
      chk("rst_stall", {31'b0, stall_EX}, {31'b0, (c < rc)});
      chk("rst_done", {31'b0, done}, 32'd0);
      if (c == rc + 2) chk("rst_result", result, 32'd0);
      @(posedge clk); #1;
      if (c == rc - 1) begin rst = 1'b1; start = 1'b0; end
      if (c == rc + 1) rst = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] corners[6];
    logic [3:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF; corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF; corners[5] = 32'hFFFF_FFFD;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 4'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1; start = 1'b1; op = 4'b0101; a = 32'd9; b = 32'd9;
    @(negedge clk);
    chk("reset_stall", {31'b0, stall_EX}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    idle(1);

    run_op(4'b0101, 32'd7, 32'd6);
    idle(1);
    run_op(4'b0110, 32'hFFFF_FFFD, 32'd2);
    run_op(4'b0110, 32'h8000_0000, 32'h8000_0000);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(4'b0011, 32'd4, 32'd4);
    idle(1);

    run_flush(4'b0101, 32'd123, 32'd456, 10);
    run_op(4'b0110, 32'h1234_5678, 32'h8765_4321);
    idle(2);

    run_reset(4'b0111, 32'hDEAD_BEEF, 32'hCAFE_F00D, 20);
    run_op(4'b0101, 32'd3, 32'd5);

    for (int i = 0; i < 20; i++) begin
      ro = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'($urandom_range(5, 7));
      rx = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      ry = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      run_op(ro, rx, ry);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end

    idle(3);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
